// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter and its condition detector.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      StWaitFree,
      StFree,
      StOwned,
      StExtBusy
   } arb_state_t;

   localparam int unsigned DefaultBusFreeCycles = 64;
   localparam int unsigned MaxNumReq            = 8;

endpackage

// File: rtl/i2c_bus_condition_detector.sv
// Detects I2C START/STOP conditions and SCL rising edges from conditioned line levels.
module i2c_bus_condition_detector (
   input  logic fastClock,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic start,
   output logic stop,
   output logic sclRise
);

   logic scl_prev;
   logic sda_prev;

   // Idle-high reset values so a bus already idle produces no spurious edge.
   always_ff @(posedge fastClock) begin
      if (reset) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl;
         sda_prev <= sda;
      end
   end

   assign start   = scl_prev & scl & sda_prev & ~sda;
   assign stop    = scl_prev & scl & ~sda_prev & sda;
   assign sclRise = ~scl_prev & scl;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner selection for a shared I2C bus; grants only after a full bus-free
// interval and revokes ownership on multi-master arbitration loss.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned BUS_FREE_CYCLES = DefaultBusFreeCycles
) (
   input  logic               fastClock,
   input  logic               reset,
   input  logic               sclDebounced,
   input  logic               sdaDebounced,
   input  logic [NUM_REQ-1:0] request,
   input  logic [NUM_REQ-1:0] releaseReq,
   input  logic               sdaDriveLow,
   output logic [NUM_REQ-1:0] grant,
   output logic               busBusy,
   output logic               startDetected,
   output logic               stopDetected,
   output logic               arbitrationLost
);

   localparam int unsigned CntW = $clog2(BUS_FREE_CYCLES + 1);
   localparam int unsigned PtrW = $clog2(NUM_REQ);
   localparam logic [CntW-1:0]    CntLast = CntW'(BUS_FREE_CYCLES - 1);
   localparam logic [CntW-1:0]    CntMax  = {CntW{1'b1}};
   localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

   arb_state_t     state_q;
   logic [CntW-1:0] cnt_q;
   logic [PtrW-1:0] ptr_q;

   logic start;
   logic stop;
   logic scl_rise;
   logic lines_high;
   logic owner_release;
   logic lost;

   logic            pick_valid;
   logic [PtrW-1:0] pick_idx;

   i2c_bus_condition_detector u_cond (
      .fastClock (fastClock),
      .reset     (reset),
      .scl       (sclDebounced),
      .sda       (sdaDebounced),
      .start     (start),
      .stop      (stop),
      .sclRise   (scl_rise)
   );

   assign lines_high    = sclDebounced & sdaDebounced;
   assign owner_release = |(releaseReq & grant);
   // Owner wanted SDA released (high) but the line reads low on the SCL rise.
   assign lost          = scl_rise & ~sdaDriveLow & ~sdaDebounced;

   // Search begins one past the last owner, so a sole requester wraps round to itself.
   always_comb begin
      int cand;
      cand       = 0;
      pick_valid = 1'b0;
      pick_idx   = ptr_q;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         cand = (int'(ptr_q) + i) % int'(NUM_REQ);
         if (!pick_valid && request[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = PtrW'(cand);
         end
      end
   end

   always_ff @(posedge fastClock) begin
      if (reset) begin
         state_q         <= StWaitFree;
         cnt_q           <= '0;
         ptr_q           <= PtrW'(NUM_REQ - 1);
         grant           <= '0;
         busBusy         <= 1'b1;
         startDetected   <= 1'b0;
         stopDetected    <= 1'b0;
         arbitrationLost <= 1'b0;
      end else begin
         startDetected   <= start;
         stopDetected    <= stop;
         arbitrationLost <= 1'b0;
         unique case (state_q)
            StWaitFree: begin
               if (start) begin
                  state_q <= StExtBusy;
                  cnt_q   <= '0;
               end else if (lines_high) begin
                  if (cnt_q == CntLast) begin
                     state_q <= StFree;
                     busBusy <= 1'b0;
                  end else if (cnt_q != CntMax) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
            StFree: begin
               if (start) begin
                  state_q <= StExtBusy;
                  busBusy <= 1'b1;
               end else if (!lines_high) begin
                  state_q <= StWaitFree;
                  cnt_q   <= '0;
                  busBusy <= 1'b1;
               end else if (pick_valid) begin
                  state_q <= StOwned;
                  grant   <= OneHot0 << pick_idx;
                  ptr_q   <= pick_idx;
                  busBusy <= 1'b1;
               end
            end
            StOwned: begin
               // Release takes precedence over a simultaneous loss.
               if (owner_release) begin
                  state_q <= StWaitFree;
                  cnt_q   <= '0;
                  grant   <= '0;
               end else if (lost) begin
                  state_q         <= StExtBusy;
                  grant           <= '0;
                  arbitrationLost <= 1'b1;
               end
            end
            StExtBusy: begin
               if (stop) begin
                  state_q <= StWaitFree;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= StWaitFree;
               cnt_q   <= '0;
               grant   <= '0;
               busBusy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with NUM_REQ=2 and BUS_FREE_CYCLES=64.
module tb_i2c_bus_arbiter;

   logic       fastClock = 1'b0;
   logic       reset;
   logic       scl;
   logic       sda;
   logic [1:0] request;
   logic [1:0] releaseReq;
   logic       sdaDriveLow;
   logic [1:0] grant;
   logic       busBusy;
   logic       startDetected;
   logic       stopDetected;
   logic       arbitrationLost;

   int checks   = 0;
   int failures = 0;

   always #5 fastClock = ~fastClock;

   i2c_bus_arbiter #(
      .NUM_REQ         (2),
      .BUS_FREE_CYCLES (64)
   ) dut (
      .fastClock       (fastClock),
      .reset           (reset),
      .sclDebounced    (scl),
      .sdaDebounced    (sda),
      .request         (request),
      .releaseReq      (releaseReq),
      .sdaDriveLow     (sdaDriveLow),
      .grant           (grant),
      .busBusy         (busBusy),
      .startDetected   (startDetected),
      .stopDetected    (stopDetected),
      .arbitrationLost (arbitrationLost)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge fastClock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      scl         = 1'b1;
      sda         = 1'b1;
      request     = 2'b00;
      releaseReq  = 2'b00;
      sdaDriveLow = 1'b0;
      step(2);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busBusy), 32'd1);
      chk("rst_start", 32'(startDetected), 32'd0);
      chk("rst_stop", 32'(stopDetected), 32'd0);
      chk("rst_lost", 32'(arbitrationLost), 32'd0);

      // Idle: free after exactly 64 high cycles
      reset = 1'b0;
      step(63);
      chk("idle_busy_63", 32'(busBusy), 32'd1);
      step(1);
      chk("idle_busy_64", 32'(busBusy), 32'd0);

      // Round robin
      request = 2'b11;
      step(1);
      chk("rr_grant0", 32'(grant), 32'd1);
      chk("rr_busy0", 32'(busBusy), 32'd1);
      releaseReq = 2'b10;
      step(1);
      releaseReq = 2'b00;
      chk("spurious_rel", 32'(grant), 32'd1);
      request = 2'b00;
      step(1);
      chk("hold_no_req", 32'(grant), 32'd1);
      request    = 2'b11;
      releaseReq = 2'b01;
      step(1);
      releaseReq = 2'b00;
      chk("rel0_grant", 32'(grant), 32'd0);
      chk("rel0_busy", 32'(busBusy), 32'd1);
      step(64);
      chk("rr_free1_busy", 32'(busBusy), 32'd0);
      chk("rr_free1_grant", 32'(grant), 32'd0);
      step(1);
      chk("rr_grant1", 32'(grant), 32'd2);
      releaseReq = 2'b10;
      step(1);
      releaseReq = 2'b00;
      chk("rel1_grant", 32'(grant), 32'd0);
      step(64);
      step(1);
      chk("rr_grant0_again", 32'(grant), 32'd1);

      // Arbitration loss with owner 0
      sda = 1'b0;
      step(1);
      chk("owned_start_pulse", 32'(startDetected), 32'd1);
      chk("owned_start_grant", 32'(grant), 32'd1);
      scl = 1'b0;
      step(1);
      chk("start_pulse_width", 32'(startDetected), 32'd0);
      scl         = 1'b1;
      sdaDriveLow = 1'b1;
      step(1);
      chk("drive_low_no_loss", 32'(arbitrationLost), 32'd0);
      chk("drive_low_grant", 32'(grant), 32'd1);
      scl = 1'b0;
      step(1);
      scl         = 1'b1;
      sdaDriveLow = 1'b0;
      step(1);
      chk("loss_grant", 32'(grant), 32'd0);
      chk("loss_pulse", 32'(arbitrationLost), 32'd1);
      chk("loss_busy", 32'(busBusy), 32'd1);
      step(1);
      chk("loss_pulse_width", 32'(arbitrationLost), 32'd0);
      chk("ext_busy_no_grant", 32'(grant), 32'd0);
      sda = 1'b1;
      step(1);
      chk("stop_pulse", 32'(stopDetected), 32'd1);
      chk("stop_busy", 32'(busBusy), 32'd1);
      request = 2'b00;
      step(1);
      chk("stop_pulse_width", 32'(stopDetected), 32'd0);
      step(62);
      chk("after_stop_busy_63", 32'(busBusy), 32'd1);
      step(1);
      chk("after_stop_free", 32'(busBusy), 32'd0);

      // START and request in the same FREE cycle
      sda     = 1'b0;
      request = 2'b10;
      step(1);
      chk("simul_start_pulse", 32'(startDetected), 32'd1);
      chk("simul_grant", 32'(grant), 32'd0);
      chk("simul_busy", 32'(busBusy), 32'd1);
      sda = 1'b1;
      step(1);
      chk("simul_stop_pulse", 32'(stopDetected), 32'd1);
      step(64);
      chk("simul_free_grant", 32'(grant), 32'd0);
      chk("simul_free_busy", 32'(busBusy), 32'd0);
      step(1);
      chk("simul_grant1", 32'(grant), 32'd2);

      // Release in the same cycle as a loss condition
      releaseReq = 2'b10;
      request    = 2'b01;
      step(1);
      releaseReq = 2'b00;
      step(65);
      chk("rvl_grant0", 32'(grant), 32'd1);
      scl = 1'b0;
      step(1);
      scl        = 1'b1;
      sda        = 1'b0;
      releaseReq = 2'b01;
      step(1);
      releaseReq = 2'b00;
      chk("rvl_grant", 32'(grant), 32'd0);
      chk("rvl_no_lost", 32'(arbitrationLost), 32'd0);
      step(1);
      chk("rvl_no_lost_later", 32'(arbitrationLost), 32'd0);
      sda = 1'b1;
      step(70);
      chk("regrant0", 32'(grant), 32'd1);

      // Reset mid-transfer
      reset = 1'b1;
      step(1);
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_busy", 32'(busBusy), 32'd1);
      reset = 1'b0;
      step(63);
      chk("midrst_grant_63", 32'(grant), 32'd0);
      chk("midrst_busy_63", 32'(busBusy), 32'd1);
      step(1);
      chk("midrst_free_grant", 32'(grant), 32'd0);
      chk("midrst_free_busy", 32'(busBusy), 32'd0);
      step(1);
      chk("midrst_grant", 32'(grant), 32'd1);

      // SCL glitch at cycle 30 restarts the free count
      request = 2'b00;
      reset   = 1'b1;
      step(1);
      reset = 1'b0;
      step(29);
      scl = 1'b0;
      step(1);
      scl = 1'b1;
      step(63);
      chk("glitch_busy_63", 32'(busBusy), 32'd1);
      step(1);
      chk("glitch_free", 32'(busBusy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Sequences access to the shared I2C bus for NUM_REQ internal masters.
- Consumes the synchronized and debounced SCL/SDA levels, detects START and STOP conditions, and tracks bus-free time.
- Grants the bus round-robin only when it is provably idle.
- Revokes the grant on multi-master arbitration loss; sits between the line conditioners and the per-master byte engines.

Parameters:
- NUM_REQ, 2: number of internal requesters, range 2..8.
- BUS_FREE_CYCLES, 64: consecutive fastClock cycles with SCL=1 and SDA=1 required before the bus counts as free; minimum 2.

Ports:
- fastClock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- sclDebounced  in  1  conditioned SCL level.
- sdaDebounced  in  1  conditioned SDA level.
- request  in  NUM_REQ  per-master bus request, level.
- release  in  NUM_REQ  per-master release pulse, issued after the master's STOP.
- sdaDriveLow  in  1  current owner's intended SDA drive (1 = pulling low).
- grant  out  NUM_REQ  one-hot or zero bus ownership.
- busBusy  out  1  bus not available to any requester.
- startDetected  out  1  one-cycle pulse.
- stopDetected  out  1  one-cycle pulse.
- arbitrationLost  out  1  one-cycle pulse.

Behaviour:
- Fixed decision: one clock, fastClock. reset is synchronous and active-high.
- Reset values:
  - grant=0, busBusy=1, all pulses=0.
  - State WAIT_FREE, free counter=0, round-robin pointer set so index 0 has priority.
  - sclPrev=1, sdaPrev=1.
- Condition detection uses registered previous samples:
  - START = sclPrev & scl & sdaPrev & !sda.
  - STOP = sclPrev & scl & !sdaPrev & sda.
  - sclRise = !sclPrev & scl.
- Pulse timing: startDetected/stopDetected go high in cycle N+1 for a condition detected from the cycle-N sample; each is exactly 1 cycle wide.
- States:
  - WAIT_FREE (busBusy=1):
    - Counter increments while scl&sda, clears otherwise.
    - START -> EXT_BUSY.
    - Counter reaching BUS_FREE_CYCLES-1 with lines still high -> FREE.
    - Counter width is clog2(BUS_FREE_CYCLES+1) and saturates; no wrap.
  - FREE (busBusy=0):
    - START -> EXT_BUSY. START has priority over request in the same cycle; no grant is issued.
    - Else, any request -> OWNED; grant registered at N+1 for request seen at N.
    - Else stay.
    - Either line low without START -> WAIT_FREE, counter=0.
  - OWNED (busBusy=1):
    - grant is held regardless of request deassertion.
    - release[owner] -> WAIT_FREE; grant=0 next cycle.
    - release from a non-owner is ignored.
    - STOP does not free the grant.
    - Arbitration loss: on sclRise with sdaDriveLow=0 and sda=0, grant=0 next cycle, arbitrationLost pulses 1 cycle, -> EXT_BUSY.
    - Same cycle release[owner] and loss: release wins, no arbitrationLost pulse.
  - EXT_BUSY (busBusy=1): STOP -> WAIT_FREE, counter=0; all requests ignored.
- Round robin:
  - Search starts at pointer+1, modulo NUM_REQ.
  - Pointer updates to the granted index on entry to OWNED.
  - A sole requester is re-granted freely.
- Reset mid-transfer: grant drops on the next edge and the FSM re-enters WAIT_FREE. Full free time is required before any grant.
- grant is never multi-hot. busBusy=0 only in FREE.

Decomposition:
- Shared package i2c_arb_pkg:
  - State enum (WAIT_FREE, FREE, OWNED, EXT_BUSY).
  - Default BUS_FREE_CYCLES.
  - Max NUM_REQ constant.
- Sub-module i2c_bus_condition_detector:
  - Holds the sclPrev/sdaPrev registers.
  - Outputs start, stop and sclRise.
  - Reused by the slave-side logic.

Test Plan:
- Idle after reset:
  - Stimulus: reset 2 cycles, then scl=sda=1 held, BUS_FREE_CYCLES=64.
  - Response: busBusy falls exactly 64 cycles after reset deasserts. A line glitch low at cycle 30 restarts the count.
- Round robin:
  - Stimulus: request=2'b11 held in FREE.
  - Response: grant=01. After release[0] and 64 free cycles, grant=10. After release[1] and 64 free cycles, grant=01.
- Simultaneous START and request:
  - Stimulus: in FREE, sda falls with scl=1 in the same cycle request[1] rises.
  - Response: startDetected pulse, grant stays 0, busBusy=1. After STOP plus 64 free cycles, grant=10.
- Arbitration loss:
  - Stimulus: owner 0, sdaDriveLow=0, sda=0 at SCL rise.
  - Response: next cycle grant=0 and arbitrationLost=1 for 1 cycle. After a STOP, stopDetected pulses and the FSM returns to WAIT_FREE.
- Release vs loss and spurious release:
  - Stimulus: release[0] in the same cycle as the loss condition.
  - Response: no arbitrationLost pulse.
  - Stimulus: release[1] while 0 owns the bus.
  - Response: grant unchanged at 01.
- Reset mid-transfer:
  - Stimulus: reset asserted while grant=01.
  - Response: grant=0 and busBusy=1 on the next edge. No grant for 64 cycles after reset release.
